mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multi-cycle control unit for the WISC-S25 16-bit core. It is the sequential successor to the single-cycle combinational decoder.
- Latches the fetched instruction and sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Handshakes with instruction and data memory, and issues one-cycle write-enable pulses (PC, IR, register file, flags).
- Opcode-to-behaviour mapping is parametrised by per-opcode masks, and memory stalls are guarded by a watchdog.

Parameters:
- INSTR_W, 16, instruction width; opcode = ir[INSTR_W-1 -: 4].
- FLAG_MASK, 16'h0077, bit n set means opcode n writes flags (ADD, SUB, XOR, SLL, SRA, ROR).
- RW_MASK, 16'h4DFF, bit n set means opcode n writes the register file (0x0-0x7, LW, LLB, LHB, PCS).
- TIMEOUT, 15, maximum wait cycles on either memory handshake; 0 disables the watchdog.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- instruction  in  INSTR_W  instruction memory read data, valid when imem_ready=1
- imem_req  out  1  instruction fetch request
- imem_ready  in  1  fetch complete
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (SW)
- dmem_ready  in  1  data access complete
- branch_taken  in  1  condition met, from flag/condition logic, sampled in EXEC
- ir_write  out  1  one-cycle pulse: IR loaded
- pc_write  out  1  one-cycle pulse: PC update
- pc_src  out  2  00 = PC+2, 01 = PC+2+(imm9<<1), 10 = register rs
- reg_write  out  1  one-cycle register file write pulse
- flag_write  out  1  one-cycle flag update pulse
- rr1_sel, rr2_sel, alu_src, mem_to_reg, pcs_sel  out  1 each  static decodes of latched IR
- imm_sel  out  2  00 = imm4, 01 = SE offset<<1, 10 = ZE imm8
- halted  out  1  core halted
- err  out  1  sticky watchdog error
- state  out  3  current state (debug)

Behaviour:
- Reset (async, rst=1): state=IDLE, ir=0, wait counter=0, err=0. All outputs 0, and static decodes equal ADD decode (all 0). Reset asserted in any state, including mid-MEM, aborts the operation immediately.
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- IDLE: one cycle, then FETCH unconditionally.
- FETCH:
  - imem_req=1 until imem_ready.
  - On the ready cycle: ir<=instruction, ir_write=1, pc_write=1, pc_src=00; next DECODE.
- DECODE: opcode 1111 goes to HALT; everything else goes to EXEC.
- EXEC:
  - flag_write=FLAG_MASK[op].
  - 1000/1001 (LW/SW): next MEM.
  - 1100/1101 (B/BR): if branch_taken, pc_write=1 and pc_src=01 (B) or 10 (BR). Next FETCH regardless of branch_taken.
  - All other opcodes: next WB.
- MEM:
  - dmem_req=1, dmem_we=(op==1001), held until dmem_ready.
  - On ready: LW goes to WB, SW goes to FETCH.
- WB: reg_write=RW_MASK[op]; next FETCH.
- Watchdog:
  - The wait counter increments each FETCH/MEM cycle without ready and clears on state exit.
  - If TIMEOUT!=0 and counter==TIMEOUT with ready still low, set err=1 and go to HALT.
  - If ready arrives on the same cycle as the timeout, ready wins.
- HALT: halted=1. All requests and pulses 0. Exit only by reset.
- Static decodes, combinational from ir:
  - rr1_sel = op==101x
  - rr2_sel = op==1001
  - imm_sel[1] = 101x; imm_sel[0] = 100x
  - alu_src = (01xx except 0111) or 100x or 101x
  - mem_to_reg = op==1000
  - pcs_sel = op==1110
- Latency with zero-wait memory: ALU/LLB/LHB/PCS 4 cycles; LW 5; SW 4; B/BR 3.
- Every pulse output is high for exactly one cycle per instruction and is never asserted outside its state.
- Opcodes whose RW_MASK bit is clear still pass through WB with reg_write=0.

Decomposition:
- Package wisc_ctrl_pkg holds: opcode localparams (OP_ADD..OP_HLT), state encodings, pc_src encodings, imm_sel encodings.
- Sub-module ctrl_decode: purely combinational static decode from opcode.
- mc_control holds the FSM, IR, watchdog counter and pulse generation.

Test Plan:
- Release rst, imem_ready=1, instruction 16'h0123 (ADD) → IDLE, FETCH, DECODE, EXEC, WB in consecutive cycles. ir_write and pc_write (pc_src=00) in FETCH; flag_write in EXEC; reg_write one cycle in WB; alu_src=0.
- LW 16'h8123 with dmem_ready high on the 4th MEM cycle → dmem_req held 4 cycles with dmem_we=0; mem_to_reg=1; imm_sel=01; reg_write pulse in WB; flag_write never high.
- SW 16'h9123 with zero-wait memory → dmem_we=1 and rr2_sel=1 in MEM; next state FETCH; reg_write never high.
- B 16'hC005: branch_taken=1 → pc_write with pc_src=01 in EXEC. branch_taken=0 → no pc_write in EXEC. Either way, FETCH follows EXEC.
- HLT 16'hF000 → halted=1 and imem_req=0 for 20 cycles. Separately, asserting rst mid-MEM → next cycle state=IDLE, dmem_req=0, err=0.
- TIMEOUT=4, LW with dmem_ready stuck low → after 4 wait cycles err=1, state=HALT, halted=1, no reg_write.

Source files
------------

// File: rtl/wisc_ctrl_pkg.sv
// Shared encodings for the WISC-S25 multi-cycle control unit: opcodes, FSM states,
// PC source and immediate select codes.
package wisc_ctrl_pkg;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StFetch  = 3'd1,
        StDecode = 3'd2,
        StExec   = 3'd3,
        StMem    = 3'd4,
        StWb     = 3'd5,
        StHalt   = 3'd6
    } ctrlState_e;

    localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_REG    = 2'b10;

    localparam logic [1:0] IMM_SEL_IMM4   = 2'b00;
    localparam logic [1:0] IMM_SEL_OFFSET = 2'b01;
    localparam logic [1:0] IMM_SEL_IMM8   = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// Static datapath selects derived purely from the latched opcode.
module ctrl_decode
    import wisc_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       rr1Sel,
    output logic       rr2Sel,
    output logic [1:0] immSel,
    output logic       aluSrc,
    output logic       memToReg,
    output logic       pcsSel
);

    logic isMem;
    logic isLoadByte;
    logic isShift;

    always_comb begin
        isMem      = (opcode == OP_LW)  || (opcode == OP_SW);
        isLoadByte = (opcode == OP_LLB) || (opcode == OP_LHB);
        // 01xx opcodes take an immediate, except PADDSB which is register-register
        isShift    = (opcode[3:2] == 2'b01) && (opcode != OP_PADDSB);

        rr1Sel   = isLoadByte;
        rr2Sel   = (opcode == OP_SW);
        aluSrc   = isShift || isMem || isLoadByte;
        memToReg = (opcode == OP_LW);
        pcsSel   = (opcode == OP_PCS);

        immSel = IMM_SEL_IMM4;
        if (isMem) begin
            immSel = IMM_SEL_OFFSET;
        end else if (isLoadByte) begin
            immSel = IMM_SEL_IMM8;
        end
    end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle control FSM for the WISC-S25 core: latches IR, sequences FETCH..WB,
// handshakes with instruction/data memory and guards stalls with a watchdog.
module mc_control
    import wisc_ctrl_pkg::*;
#(
    parameter int unsigned INSTR_W   = 16,
    parameter logic [15:0] FLAG_MASK = 16'h0077,
    parameter logic [15:0] RW_MASK   = 16'h4DFF,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instruction,
    output logic               imem_req,
    input  logic               imem_ready,
    output logic               dmem_req,
    output logic               dmem_we,
    input  logic               dmem_ready,
    input  logic               branch_taken,
    output logic               ir_write,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               reg_write,
    output logic               flag_write,
    output logic               rr1_sel,
    output logic               rr2_sel,
    output logic               alu_src,
    output logic               mem_to_reg,
    output logic               pcs_sel,
    output logic [1:0]         imm_sel,
    output logic               halted,
    output logic               err,
    output logic [2:0]         state
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 2);

    ctrlState_e         stateQ;
    logic [INSTR_W-1:0] irQ;
    logic [CntW-1:0]    waitCnt;
    logic               errQ;
    logic [3:0]         op;
    logic               timedOut;
    logic               unusedIrBits;

    assign op           = irQ[INSTR_W-1 -: 4];
    assign unusedIrBits = ^irQ[INSTR_W-5:0];
    assign timedOut     = (TIMEOUT != 0) && (waitCnt == CntW'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ  <= StIdle;
            irQ     <= '0;
            waitCnt <= '0;
            errQ    <= 1'b0;
        end else begin
            case (stateQ)
                StIdle: stateQ <= StFetch;
                StFetch: begin
                    // ready takes priority over an expiring watchdog
                    if (imem_ready) begin
                        irQ     <= instruction;
                        waitCnt <= '0;
                        stateQ  <= StDecode;
                    end else if (timedOut) begin
                        errQ    <= 1'b1;
                        waitCnt <= '0;
                        stateQ  <= StHalt;
                    end else begin
                        waitCnt <= waitCnt + CntW'(1);
                    end
                end
                StDecode: stateQ <= (op == OP_HLT) ? StHalt : StExec;
                StExec: begin
                    if ((op == OP_LW) || (op == OP_SW)) begin
                        stateQ <= StMem;
                    end else if ((op == OP_B) || (op == OP_BR)) begin
                        stateQ <= StFetch;
                    end else begin
                        stateQ <= StWb;
                    end
                end
                StMem: begin
                    if (dmem_ready) begin
                        waitCnt <= '0;
                        stateQ  <= (op == OP_LW) ? StWb : StFetch;
                    end else if (timedOut) begin
                        errQ    <= 1'b1;
                        waitCnt <= '0;
                        stateQ  <= StHalt;
                    end else begin
                        waitCnt <= waitCnt + CntW'(1);
                    end
                end
                StWb:   stateQ <= StFetch;
                StHalt: stateQ <= StHalt;
                default: stateQ <= StIdle;
            endcase
        end
    end

    // Pulses follow the handshake inputs within the same cycle
    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = PC_SRC_SEQ;
        flag_write = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        reg_write  = 1'b0;
        halted     = 1'b0;
        case (stateQ)
            StFetch: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
                pc_write = imem_ready;
            end
            StExec: begin
                flag_write = FLAG_MASK[op];
                if (((op == OP_B) || (op == OP_BR)) && branch_taken) begin
                    pc_write = 1'b1;
                    pc_src   = (op == OP_B) ? PC_SRC_BRANCH : PC_SRC_REG;
                end
            end
            StMem: begin
                dmem_req = 1'b1;
                dmem_we  = (op == OP_SW);
            end
            StWb:   reg_write = RW_MASK[op];
            StHalt: halted = 1'b1;
            default: ;
        endcase
    end

    assign err   = errQ;
    assign state = stateQ;

    ctrl_decode uDecode (
        .opcode   (op),
        .rr1Sel   (rr1_sel),
        .rr2Sel   (rr2_sel),
        .immSel   (imm_sel),
        .aluSrc   (alu_src),
        .memToReg (mem_to_reg),
        .pcsSel   (pcs_sel)
    );

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: per-cycle stimulus and expected outputs are queued,
// then replayed and compared one cycle at a time.
module tb_mc_control;

    localparam int unsigned TO    = 4;
    localparam logic [15:0] FLAGS = 16'h0077;
    localparam logic [15:0] RWS   = 16'h4DFF;

    logic        clk;
    logic        rst;
    logic [15:0] instruction;
    logic        imem_req, imem_ready, dmem_req, dmem_we, dmem_ready, branch_taken;
    logic        ir_write, pc_write, reg_write, flag_write;
    logic [1:0]  pc_src, imm_sel;
    logic        rr1_sel, rr2_sel, alu_src, mem_to_reg, pcs_sel, halted, err;
    logic [2:0]  state;

    mc_control #(
        .INSTR_W   (16),
        .FLAG_MASK (FLAGS),
        .RW_MASK   (RWS),
        .TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instruction  (instruction),
        .imem_req     (imem_req),
        .imem_ready   (imem_ready),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ready   (dmem_ready),
        .branch_taken (branch_taken),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .flag_write   (flag_write),
        .rr1_sel      (rr1_sel),
        .rr2_sel      (rr2_sel),
        .alu_src      (alu_src),
        .mem_to_reg   (mem_to_reg),
        .pcs_sel      (pcs_sel),
        .imm_sel      (imm_sel),
        .halted       (halted),
        .err          (err),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        imemReady;
        logic        dmemReady;
        logic        branchTaken;
        logic [15:0] instr;
    } stim_t;

    typedef struct packed {
        logic [2:0] st;
        logic       imemReq;
        logic       irWrite;
        logic       pcWrite;
        logic [1:0] pcSrc;
        logic       regWrite;
        logic       flagWrite;
        logic       dmemReq;
        logic       dmemWe;
        logic       halted;
        logic       err;
        logic [6:0] dec;   // {rr1, rr2, imm_sel[1:0], alu_src, mem_to_reg, pcs_sel}
    } obs_t;

    stim_t       stimQ[$];
    obs_t        expQ[$];
    int          checks;
    int          failures;
    logic [3:0]  curOp;
    logic        errExp;

    function automatic logic [6:0] expDec(input logic [3:0] op);
        case (op)
            4'h4, 4'h5, 4'h6: return 7'b0000100;
            4'h8:             return 7'b0001110;
            4'h9:             return 7'b0101100;
            4'hA, 4'hB:       return 7'b1010100;
            4'hE:             return 7'b0000001;
            default:          return 7'b0000000;
        endcase
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st        = state;
        o.imemReq   = imem_req;
        o.irWrite   = ir_write;
        o.pcWrite   = pc_write;
        o.pcSrc     = pc_src;
        o.regWrite  = reg_write;
        o.flagWrite = flag_write;
        o.dmemReq   = dmem_req;
        o.dmemWe    = dmem_we;
        o.halted    = halted;
        o.err       = err;
        o.dec       = {rr1_sel, rr2_sel, imm_sel, alu_src, mem_to_reg, pcs_sel};
        return o;
    endfunction

    // Outside their own state every handshake input is driven high to expose leaks
    function automatic stim_t junk();
        stim_t s;
        s.imemReady   = 1'b1;
        s.dmemReady   = 1'b1;
        s.branchTaken = 1'b1;
        s.instr       = 16'($urandom);
        return s;
    endfunction

    function automatic obs_t base(input logic [2:0] st);
        obs_t o;
        o     = '0;
        o.st  = st;
        o.dec = expDec(curOp);
        o.err = errExp;
        return o;
    endfunction

    task automatic pushIdle();
        stimQ.push_back(junk());
        expQ.push_back(base(3'd0));
    endtask

    task automatic pushFetch(input logic [15:0] instr, input logic ready);
        stim_t s;
        obs_t  o;
        s           = junk();
        s.imemReady = ready;
        s.instr     = instr;
        o           = base(3'd1);
        o.imemReq   = 1'b1;
        o.irWrite   = ready;
        o.pcWrite   = ready;
        stimQ.push_back(s);
        expQ.push_back(o);
        if (ready) curOp = instr[15:12];
    endtask

    task automatic pushDecode();
        stimQ.push_back(junk());
        expQ.push_back(base(3'd2));
    endtask

    task automatic pushExec(input logic bt);
        stim_t s;
        obs_t  o;
        s             = junk();
        s.branchTaken = bt;
        o             = base(3'd3);
        o.flagWrite   = FLAGS[curOp];
        if (bt && (curOp == 4'hC || curOp == 4'hD)) begin
            o.pcWrite = 1'b1;
            o.pcSrc   = (curOp == 4'hC) ? 2'b01 : 2'b10;
        end
        stimQ.push_back(s);
        expQ.push_back(o);
    endtask

    task automatic pushMem(input logic ready);
        stim_t s;
        obs_t  o;
        s           = junk();
        s.dmemReady = ready;
        o           = base(3'd4);
        o.dmemReq   = 1'b1;
        o.dmemWe    = (curOp == 4'h9);
        stimQ.push_back(s);
        expQ.push_back(o);
    endtask

    task automatic pushWb();
        obs_t o;
        o          = base(3'd5);
        o.regWrite = RWS[curOp];
        stimQ.push_back(junk());
        expQ.push_back(o);
    endtask

    task automatic pushHalt();
        obs_t o;
        o        = base(3'd6);
        o.halted = 1'b1;
        stimQ.push_back(junk());
        expQ.push_back(o);
    endtask

    task automatic test_reset();
        obs_t a;
        rst          = 1'b1;
        imem_ready   = 1'b1;
        dmem_ready   = 1'b1;
        branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            a = sample();
            checks++;
            if (a !== obs_t'('0)) begin
                failures++;
                $display("FAIL reset[%0d]: got %h expected %h", i, a, obs_t'('0));
            end
            @(negedge clk);
        end
        rst    = 1'b0;
        curOp  = 4'h0;
        errExp = 1'b0;
    endtask

    task automatic test_add();
        stim_t s;
        obs_t  e, a;
        int    idx;
        pushIdle();
        pushFetch(16'h0123, 1'b1);
        pushDecode();
        pushExec(1'b0);
        pushWb();
        idx = 0;
        while (stimQ.size() > 0) begin
            s = stimQ.pop_front();
            e = expQ.pop_front();
            imem_ready = s.imemReady; dmem_ready = s.dmemReady;
            branch_taken = s.branchTaken; instruction = s.instr;
            #1;
            a = sample();
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL add[%0d]: got %h expected %h", idx, a, e);
            end
            idx++;
            @(negedge clk);
        end
    endtask

    task automatic test_lw_sw();
        stim_t s;
        obs_t  e, a;
        int    idx;
        pushFetch(16'h8123, 1'b1);
        pushDecode();
        pushExec(1'b1);
        pushMem(1'b0); pushMem(1'b0); pushMem(1'b0); pushMem(1'b1);
        pushWb();
        pushFetch(16'h9123, 1'b1);
        pushDecode();
        pushExec(1'b1);
        pushMem(1'b1);
        idx = 0;
        while (stimQ.size() > 0) begin
            s = stimQ.pop_front();
            e = expQ.pop_front();
            imem_ready = s.imemReady; dmem_ready = s.dmemReady;
            branch_taken = s.branchTaken; instruction = s.instr;
            #1;
            a = sample();
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL lw_sw[%0d]: got %h expected %h", idx, a, e);
            end
            idx++;
            @(negedge clk);
        end
    endtask

    task automatic test_branch();
        stim_t s;
        obs_t  e, a;
        int    idx;
        pushFetch(16'hC005, 1'b1); pushDecode(); pushExec(1'b1);
        pushFetch(16'hC005, 1'b1); pushDecode(); pushExec(1'b0);
        pushFetch(16'hD000, 1'b1); pushDecode(); pushExec(1'b1);
        pushFetch(16'hD000, 1'b1); pushDecode(); pushExec(1'b0);
        idx = 0;
        while (stimQ.size() > 0) begin
            s = stimQ.pop_front();
            e = expQ.pop_front();
            imem_ready = s.imemReady; dmem_ready = s.dmemReady;
            branch_taken = s.branchTaken; instruction = s.instr;
            #1;
            a = sample();
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL branch[%0d]: got %h expected %h", idx, a, e);
            end
            idx++;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        obs_t  e, a;
        int    idx;
        logic [15:0] prog [5] = '{16'hA123, 16'h7456, 16'h5789, 16'h3abc, 16'hE000};
        for (int i = 0; i < 5; i++) begin
            pushFetch(prog[i], 1'b1); pushDecode(); pushExec(1'b1); pushWb();
        end
        // Ready arriving exactly as the watchdog expires must win, on both handshakes
        for (int i = 0; i < 4; i++) pushFetch(16'h8abc, 1'b0);
        pushFetch(16'h8abc, 1'b1);
        pushDecode();
        pushExec(1'b0);
        for (int i = 0; i < 4; i++) pushMem(1'b0);
        pushMem(1'b1);
        pushWb();
        idx = 0;
        while (stimQ.size() > 0) begin
            s = stimQ.pop_front();
            e = expQ.pop_front();
            imem_ready = s.imemReady; dmem_ready = s.dmemReady;
            branch_taken = s.branchTaken; instruction = s.instr;
            #1;
            a = sample();
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", idx, a, e);
            end
            idx++;
            @(negedge clk);
        end
    endtask

    task automatic test_mem_reset();
        stim_t s;
        obs_t  e, a;
        int    idx;
        pushFetch(16'h8123, 1'b1); pushDecode(); pushExec(1'b0);
        pushMem(1'b0); pushMem(1'b0);
        idx = 0;
        while (stimQ.size() > 0) begin
            s = stimQ.pop_front();
            e = expQ.pop_front();
            imem_ready = s.imemReady; dmem_ready = s.dmemReady;
            branch_taken = s.branchTaken; instruction = s.instr;
            #1;
            a = sample();
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL mem_reset[%0d]: got %h expected %h", idx, a, e);
            end
            idx++;
            @(negedge clk);
        end
        dmem_ready = 1'b0;
        rst        = 1'b1;
        #1;
        checks++;
        if ({state, dmem_req, err} !== 5'b0) begin
            failures++;
            $display("FAIL mem_reset_abort: got st=%0d dmem_req=%b err=%b expected 0 0 0",
                     state, dmem_req, err);
        end
        @(negedge clk);
        #1;
        a = sample();
        checks++;
        if (a !== obs_t'('0)) begin
            failures++;
            $display("FAIL mem_reset_hold: got %h expected %h", a, obs_t'('0));
        end
        @(negedge clk);
        rst    = 1'b0;
        curOp  = 4'h0;
        errExp = 1'b0;
    endtask

    task automatic test_timeout();
        stim_t s;
        obs_t  e, a;
        int    idx;
        pushIdle();
        pushFetch(16'h8123, 1'b1); pushDecode(); pushExec(1'b0);
        for (int i = 0; i <= TO; i++) pushMem(1'b0);
        errExp = 1'b1;
        for (int i = 0; i < 4; i++) pushHalt();
        idx = 0;
        while (stimQ.size() > 0) begin
            s = stimQ.pop_front();
            e = expQ.pop_front();
            imem_ready = s.imemReady; dmem_ready = s.dmemReady;
            branch_taken = s.branchTaken; instruction = s.instr;
            // a stuck data memory never answers
            if (e.st == 3'd4 || e.st == 3'd6) dmem_ready = 1'b0;
            #1;
            a = sample();
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL timeout[%0d]: got %h expected %h", idx, a, e);
            end
            idx++;
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        stim_t s;
        obs_t  e, a;
        int    idx;
        pushIdle();
        pushFetch(16'hF000, 1'b1);
        pushDecode();
        for (int i = 0; i < 20; i++) pushHalt();
        idx = 0;
        while (stimQ.size() > 0) begin
            s = stimQ.pop_front();
            e = expQ.pop_front();
            imem_ready = s.imemReady; dmem_ready = s.dmemReady;
            branch_taken = s.branchTaken; instruction = s.instr;
            #1;
            a = sample();
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL halt[%0d]: got %h expected %h", idx, a, e);
            end
            idx++;
            @(negedge clk);
        end
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        curOp        = 4'h0;
        errExp       = 1'b0;
        rst          = 1'b1;
        instruction  = 16'h0000;
        imem_ready   = 1'b0;
        dmem_ready   = 1'b0;
        branch_taken = 1'b0;
        @(negedge clk);
        test_reset();
        test_add();
        test_lw_sw();
        test_branch();
        test_back_to_back();
        test_mem_reset();
        test_timeout();
        test_reset();
        test_halt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
